// File: rtl/alu_ctrl.sv
// alu_ctrl: front-end controller for a small ALU demo board.
//
// A bouncy push-button (click) is synchronized and debounced. Each clean press
// advances the operation select (mode), samples the operand switches into
// op_a/op_b, lets the external ALU settle for EXEC_CYC cycles, then captures
// the ALU result and flags and drives two active-low 7-segment digits.
//
// Ports
//   clk                     : single clock, rising edge
//   rst                     : synchronous active-high reset
//   click                   : raw asynchronous push-button, active-high
//   in1, in2 [n-1:0]        : operand switches (asynchronous)
//   alu_num [7:0]           : combinational ALU result
//   alu_neg/cero/carry/des  : ALU flags
//   mode [2:0]              : ALU operation select (0 add .. 7 shr)
//   op_a, op_b [n-1:0]      : registered operands to the ALU
//   num [7:0]               : captured result
//   neg/cero/carry/des      : captured flags
//   busy                    : high while an operation is in flight
//   out [1:0][6:0]          : active-low 7-seg, out[0] low nibble, out[1] high
`timescale 1ns/1ps

module alu_ctrl #(
  parameter int n        = 4,
  parameter int DB_CYC   = 4,
  parameter int EXEC_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            click,
  input  logic [n-1:0]    in1,
  input  logic [n-1:0]    in2,
  input  logic [7:0]      alu_num,
  input  logic            alu_neg,
  input  logic            alu_cero,
  input  logic            alu_carry,
  input  logic            alu_des,
  output logic [2:0]      mode,
  output logic [n-1:0]    op_a,
  output logic [n-1:0]    op_b,
  output logic [7:0]      num,
  output logic            neg,
  output logic            cero,
  output logic            carry,
  output logic            des,
  output logic            busy,
  output logic [1:0][6:0] out
);

  localparam int DW = $clog2(DB_CYC + 1);
  localparam int EW = $clog2(EXEC_CYC + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYC - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [EW-1:0] EX_LAST = EW'(EXEC_CYC - 1);
  localparam logic [EW-1:0] EX_ONE  = EW'(1);
  localparam logic [6:0]    SEG_ZERO = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2
  } state_t;

  // Active-low hex digit, bit6 = g ... bit0 = a.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic            click_meta_r;
  logic            click_sync_r;
  logic            db_level_r;
  logic            db_prev_r;
  logic [DW-1:0]   db_cnt_r;
  logic            press_s;

  state_t          state_r;
  state_t          state_s;
  logic [EW-1:0]   exec_cnt_r;
  logic [EW-1:0]   exec_cnt_s;
  logic [2:0]      mode_s;
  logic [n-1:0]    op_a_s;
  logic [n-1:0]    op_b_s;
  logic [7:0]      num_s;
  logic [3:0]      flags_s;
  logic            busy_s;
  logic [1:0][6:0] out_s;

  // Synchronizer and debouncer: the level follows the synchronized button only
  // after it has differed for DB_CYC consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      click_meta_r <= 1'b0;
      click_sync_r <= 1'b0;
      db_level_r   <= 1'b0;
      db_prev_r    <= 1'b0;
      db_cnt_r     <= {DW{1'b0}};
    end else begin
      click_meta_r <= click;
      click_sync_r <= click_meta_r;
      db_prev_r    <= db_level_r;
      if (click_sync_r == db_level_r) begin
        db_cnt_r <= {DW{1'b0}};
      end else if (db_cnt_r == DB_LAST) begin
        db_level_r <= click_sync_r;
        db_cnt_r   <= {DW{1'b0}};
      end else begin
        db_cnt_r <= db_cnt_r + DB_ONE;
      end
    end
  end

  // One-cycle pulse on the debounced rising edge only.
  assign press_s = db_level_r & ~db_prev_r;

  // Next-state and next-output logic; everything holds unless the FSM acts.
  always_comb begin
    state_s    = state_r;
    exec_cnt_s = exec_cnt_r;
    mode_s     = mode;
    op_a_s     = op_a;
    op_b_s     = op_b;
    num_s      = num;
    flags_s    = {neg, cero, carry, des};
    busy_s     = busy;
    out_s      = out;
    case (state_r)
      IDLE: begin
        if (press_s) begin
          mode_s  = mode + 3'd1;
          op_a_s  = in1;
          op_b_s  = in2;
          busy_s  = 1'b1;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        exec_cnt_s = {EW{1'b0}};
        state_s    = EXEC;
      end
      EXEC: begin
        // Presses arriving here (including the capture cycle) are dropped.
        if (exec_cnt_r == EX_LAST) begin
          num_s    = alu_num;
          flags_s  = {alu_neg, alu_cero, alu_carry, alu_des};
          out_s[0] = seg7(alu_num[3:0]);
          out_s[1] = seg7(alu_num[7:4]);
          busy_s   = 1'b0;
          state_s  = IDLE;
        end else begin
          exec_cnt_s = exec_cnt_r + EX_ONE;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation without capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r                  <= IDLE;
      exec_cnt_r               <= {EW{1'b0}};
      mode                     <= 3'd0;
      op_a                     <= {n{1'b0}};
      op_b                     <= {n{1'b0}};
      num                      <= 8'h00;
      {neg, cero, carry, des}  <= 4'b0000;
      busy                     <= 1'b0;
      out                      <= {SEG_ZERO, SEG_ZERO};
    end else begin
      state_r                  <= state_s;
      exec_cnt_r               <= exec_cnt_s;
      mode                     <= mode_s;
      op_a                     <= op_a_s;
      op_b                     <= op_b_s;
      num                      <= num_s;
      {neg, cero, carry, des}  <= flags_s;
      busy                     <= busy_s;
      out                      <= out_s;
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl. A default-parameter instance covers the main
// flow; a second instance with a long settle time makes press-while-busy and
// press-on-capture timing reachable with the default debounce.
`timescale 1ns/1ps

module tb_alu_ctrl;

  localparam int N   = 4;
  localparam int DB  = 4;
  localparam int EX  = 2;
  localparam int EXL = 20;

  localparam logic [6:0] S0 = 7'b1000000;

  // Hand-computed results for in1=C, in2=A, press i -> mode (i+1)%8.
  localparam logic [7:0] EXP_NUM [8] = '{8'h02, 8'h78, 8'h08, 8'h0E, 8'h06, 8'h30, 8'h03, 8'h16};
  localparam logic [6:0] EXP_LO  [8] = '{7'b0100100, 7'b0000000, 7'b0000000, 7'b0000110,
                                          7'b0000010, 7'b1000000, 7'b0110000, 7'b0000010};
  localparam logic [6:0] EXP_HI  [8] = '{7'b1000000, 7'b1111000, 7'b1000000, 7'b1000000,
                                          7'b1000000, 7'b0110000, 7'b1000000, 7'b1111001};
  localparam logic [1:0] EXP_CD  [8] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};

  logic clk = 1'b0;
  logic rst;
  logic click;
  logic [N-1:0] in1, in2;

  logic [7:0] alu_num, l_alu_num;
  logic alu_neg, alu_cero, alu_carry, alu_des;
  logic l_alu_neg, l_alu_cero, l_alu_carry, l_alu_des;

  logic [2:0] mode, l_mode;
  logic [N-1:0] op_a, op_b, l_op_a, l_op_b;
  logic [7:0] num, l_num;
  logic neg, cero, carry, des, busy;
  logic l_neg, l_cero, l_carry, l_des, l_busy;
  logic [1:0][6:0] out, l_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // ALU stand-in: {neg, cero, carry, des, num}; carry/des are simply num[4]/num[0].
  function automatic logic [11:0] alu_f(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ax, bx, x;
    ax = {4'h0, a};
    bx = {4'h0, b};
    case (m)
      3'd0: x = ax + bx;
      3'd1: x = ax - bx;
      3'd2: x = ax * bx;
      3'd3: x = ax & bx;
      3'd4: x = ax | bx;
      3'd5: x = ax ^ bx;
      3'd6: x = ax << b[1:0];
      3'd7: x = ax >> b[1:0];
      default: x = 8'h00;
    endcase
    return {x[7], (x == 8'h00), x[4], x[0], x};
  endfunction

  always_comb {alu_neg, alu_cero, alu_carry, alu_des, alu_num} = alu_f(mode, op_a, op_b);
  always_comb {l_alu_neg, l_alu_cero, l_alu_carry, l_alu_des, l_alu_num} = alu_f(l_mode, l_op_a, l_op_b);

  alu_ctrl #(.n(N), .DB_CYC(DB), .EXEC_CYC(EX)) u_dut (
    .clk(clk), .rst(rst), .click(click), .in1(in1), .in2(in2),
    .alu_num(alu_num), .alu_neg(alu_neg), .alu_cero(alu_cero),
    .alu_carry(alu_carry), .alu_des(alu_des),
    .mode(mode), .op_a(op_a), .op_b(op_b), .num(num),
    .neg(neg), .cero(cero), .carry(carry), .des(des),
    .busy(busy), .out(out)
  );

  alu_ctrl #(.n(N), .DB_CYC(DB), .EXEC_CYC(EXL)) u_long (
    .clk(clk), .rst(rst), .click(click), .in1(in1), .in2(in2),
    .alu_num(l_alu_num), .alu_neg(l_alu_neg), .alu_cero(l_alu_cero),
    .alu_carry(l_alu_carry), .alu_des(l_alu_des),
    .mode(l_mode), .op_a(l_op_a), .op_b(l_op_b), .num(l_num),
    .neg(l_neg), .cero(l_cero), .carry(l_carry), .des(l_des),
    .busy(l_busy), .out(l_out)
  );

  // Count operation starts and real captures (busy falls not caused by reset).
  int d_starts = 0, d_caps = 0, l_starts = 0, l_caps = 0;
  logic d_bq = 1'b0, l_bq = 1'b0, rst_q = 1'b1;
  always @(posedge clk) begin
    rst_q <= rst;
    d_bq  <= busy;
    l_bq  <= l_busy;
    if (busy === 1'b1 && d_bq === 1'b0) d_starts <= d_starts + 1;
    if (busy === 1'b0 && d_bq === 1'b1 && rst_q === 1'b0) d_caps <= d_caps + 1;
    if (l_busy === 1'b1 && l_bq === 1'b0) l_starts <= l_starts + 1;
    if (l_busy === 1'b0 && l_bq === 1'b1 && rst_q === 1'b0) l_caps <= l_caps + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    click = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Clean press on the default instance; checks busy rises and stays high
  // for LOAD + EXEC_CYC cycles, then lets the release settle.
  task automatic do_press();
    int k;
    click = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("busy_rise", {31'd0, busy}, 32'd1);
    click = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < 40);
    check_val("busy_len", k, EX + 1);
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic wait_l_busy(input logic lvl, input string tag);
    int k;
    k = 0;
    while (l_busy !== lvl && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, {31'd0, l_busy}, {31'd0, lvl});
  endtask

  initial begin
    int sb, cb, lsb, lcb, k;
    rst = 1'b1;
    click = 1'b0;
    in1 = 4'h0;
    in2 = 4'h0;
    repeat (3) @(negedge clk);
    // Reset state
    check_val("rst_mode", {29'd0, mode}, 32'd0);
    check_val("rst_ops", {24'd0, op_a, op_b}, 32'd0);
    check_val("rst_num", {24'd0, num}, 32'd0);
    check_val("rst_flags", {28'd0, neg, cero, carry, des}, 32'd0);
    check_val("rst_busy", {30'd0, busy, l_busy}, 32'd0);
    check_val("rst_out", {18'd0, out}, {18'd0, S0, S0});
    rst = 1'b0;
    @(negedge clk);

    // Eight clean presses: mode 1..7 then wraps to 0, one capture each
    in1 = 4'hC;
    in2 = 4'hA;
    sb = d_starts;
    cb = d_caps;
    for (int i = 0; i < 8; i++) begin
      do_press();
      check_val("seq_mode", {29'd0, mode}, {29'd0, 3'(i + 1)});
      check_val("seq_num", {24'd0, num}, {24'd0, EXP_NUM[i]});
      check_val("seq_out0", {25'd0, out[0]}, {25'd0, EXP_LO[i]});
      check_val("seq_out1", {25'd0, out[1]}, {25'd0, EXP_HI[i]});
      check_val("seq_cd", {30'd0, carry, des}, {30'd0, EXP_CD[i]});
      check_val("seq_nz", {30'd0, neg, cero}, 32'd0);
    end
    check_val("seq_starts", d_starts - sb, 8);
    check_val("seq_caps", d_caps - cb, 8);

    // Bouncy click: single-cycle 1-0-1-0 then steady high -> one press
    do_reset();
    sb = d_starts;
    for (int i = 0; i < 4; i++) begin
      click = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    click = 1'b1;
    repeat (DB + 2) @(negedge clk);
    repeat (12) @(negedge clk);
    click = 1'b0;
    repeat (12) @(negedge clk);
    check_val("bounce_mode", {29'd0, mode}, 32'd1);
    check_val("bounce_starts", d_starts - sb, 1);

    // Long instance: press while busy, then press landing on the capture edge
    do_reset();
    lsb = l_starts;
    lcb = l_caps;
    click = 1'b1;
    wait_l_busy(1'b1, "l_rise1");
    for (k = 0; k < 14; k++) begin
      click = (k >= 7) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    click = 1'b0;
    wait_l_busy(1'b0, "l_fall1");
    repeat (12) @(negedge clk);
    check_val("busy_press_mode", {29'd0, l_mode}, 32'd1);
    check_val("busy_press_starts", l_starts - lsb, 1);
    click = 1'b1;
    wait_l_busy(1'b1, "l_rise2");
    // Low N0..N13, high from N14: debounced pulse acts on edge B+EXL+1.
    for (k = 0; k < 14; k++) begin
      click = 1'b0;
      @(negedge clk);
    end
    click = 1'b1;
    repeat (12) @(negedge clk);
    click = 1'b0;
    repeat (40) @(negedge clk);
    check_val("cap_press_mode", {29'd0, l_mode}, 32'd2);
    check_val("cap_press_starts", l_starts - lsb, 2);
    check_val("cap_press_caps", l_caps - lcb, 2);
    check_val("cap_press_busy", {31'd0, l_busy}, 32'd0);

    // Reset in the second EXEC cycle after num = 0F
    do_reset();
    in1 = 4'h5;
    in2 = 4'hA;
    for (int i = 0; i < 4; i++) do_press();
    check_val("pre_abort_num", {24'd0, num}, 32'h0F);
    click = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    click = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_num", {24'd0, num}, 32'd0);
    check_val("abort_out", {18'd0, out}, {18'd0, S0, S0});
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_mode", {29'd0, mode}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("abort_nocap", {24'd0, num}, 32'd0);
    do_press();
    check_val("post_abort_mode", {29'd0, mode}, 32'd1);
    check_val("post_abort_num", {24'd0, num}, 32'hFB);

    // Operand switch change during EXEC does not disturb the operation
    do_reset();
    in1 = 4'h3;
    in2 = 4'hA;
    click = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("hold_rise", {31'd0, busy}, 32'd1);
    click = 1'b0;
    @(negedge clk);
    in1 = 4'hC;
    @(negedge clk);
    check_val("hold_opa", {28'd0, op_a}, 32'h3);
    k = 0;
    while (busy !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("hold_num", {24'd0, num}, 32'hF9);
    check_val("hold_neg", {31'd0, neg}, 32'd1);
    check_val("hold_out0", {25'd0, out[0]}, {25'd0, 7'b0010000});
    check_val("hold_out1", {25'd0, out[1]}, {25'd0, 7'b0001110});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
